dtc_tx_sched: RTL and testbench

Request scheduler in front of the DTC transmitter. It collects readout triggers, slow-control register reads and status requests, holds them pending, and issues exactly one single-cycle command at a time to the transmitter, only when the transmitter is idle. It also supplies the address/data/valid handshake for register read replies, with a timeout so the transmitter can never hang waiting for read data. The block sits between the trigger/slow-control logic and the transmitter, entirely in the dtc_clk domain.

---
 rtl/dtc_tx_sched.sv | 217 +++++++++++++++++++++
 tb/tb_dtc_tx_sched.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtc_tx_sched.sv
// dtc_tx_sched: collects readout, register-read and status requests and issues
// them one at a time to the DTC transmitter while it is idle. It also drives the
// read-reply address/data handshake, with a dummy reply if read data never arrives.
module dtc_tx_sched #(
    parameter int unsigned RDO_DEPTH   = 4,
    parameter int unsigned RD_TIMEOUT  = 255,
    parameter int unsigned START_LIMIT = 15,
    parameter logic [31:0] RD_DUMMY    = 32'hDEAD_DEAD
) (
    input  logic        dtc_clk,
    input  logic        rst,
    input  logic        trig_rdo,
    input  logic        rd_req,
    input  logic [31:0] rd_addr,
    input  logic        st_req,
    input  logic [31:0] rd_data,
    input  logic        rd_data_vld,
    input  logic        clr_flags,
    input  logic        tx_idle,
    output logic        tx_rdocmd,
    output logic        tx_read,
    output logic        tx_streq,
    output logic [31:0] tx_address,
    output logic [31:0] tx_data,
    output logic        tx_data_vld,
    output logic [2:0]  rdo_pending,
    output logic        busy,
    output logic        rdo_overflow,
    output logic        rd_drop,
    output logic        rd_timeout,
    output logic        tx_lost
);

    localparam int unsigned TO_W = $clog2(RD_TIMEOUT + 1);
    localparam int unsigned SL_W = $clog2(START_LIMIT + 1);
    localparam logic [2:0]      RDO_MAX = 3'(RDO_DEPTH);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(RD_TIMEOUT);
    localparam logic [SL_W-1:0] SL_LAST = SL_W'(START_LIMIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_START,
        S_WAIT_DONE
    } state_t;

    typedef enum logic [1:0] {
        K_NONE,
        K_RDO,
        K_RD,
        K_ST
    } kind_t;

    state_t          state_q;
    kind_t           cur_kind_q;
    kind_t           sel_kind;
    logic [SL_W-1:0] st_cnt_q;
    logic [TO_W-1:0] to_cnt_q;

    logic [2:0]      rdo_cnt_q, rdo_cnt_d;
    logic            rd_pend_q, rd_pend_d;
    logic [31:0]     rd_addr_q, rd_addr_d;
    logic            st_pend_q, st_pend_d;

    logic            any_pend;
    logic            launch;
    logic            take_rdo, take_rd, take_st;
    logic            rd_active;
    logic            lost_evt;
    logic            to_evt;
    logic            to_idle;
    logic            ovf_evt;
    logic            drop_evt;

    // Request arbitration and transaction-level status decode
    always_comb begin
        any_pend = (rdo_cnt_q != '0) || rd_pend_q || st_pend_q;
        launch   = (state_q == S_IDLE) && tx_idle && any_pend;
        if (rdo_cnt_q != '0)
            sel_kind = K_RDO;
        else if (rd_pend_q)
            sel_kind = K_RD;
        else
            sel_kind = K_ST;
        take_rdo  = launch && (sel_kind == K_RDO);
        take_rd   = launch && (sel_kind == K_RD);
        take_st   = launch && (sel_kind == K_ST);
        rd_active = (state_q != S_IDLE) && (cur_kind_q == K_RD);
        lost_evt  = (state_q == S_WAIT_START) && tx_idle && (st_cnt_q == SL_LAST);
        to_evt    = rd_active && !tx_data_vld && !rd_data_vld && (to_cnt_q == TO_LAST);
        to_idle   = lost_evt || ((state_q == S_WAIT_DONE) && tx_idle);
    end

    // Next-state of the pending request entries; entries are consumed on the
    // same edge that raises the matching command pulse
    always_comb begin
        rdo_cnt_d = rdo_cnt_q;
        ovf_evt   = 1'b0;
        if (trig_rdo && !take_rdo) begin
            if (rdo_cnt_q == RDO_MAX)
                ovf_evt = 1'b1;
            else
                rdo_cnt_d = rdo_cnt_q + 3'd1;
        end else if (!trig_rdo && take_rdo) begin
            rdo_cnt_d = rdo_cnt_q - 3'd1;
        end

        rd_pend_d = rd_pend_q;
        rd_addr_d = rd_addr_q;
        drop_evt  = rd_req && (rd_pend_q || rd_active);
        if (rd_req && !drop_evt) begin
            rd_pend_d = 1'b1;
            rd_addr_d = rd_addr;
        end else if (take_rd) begin
            rd_pend_d = 1'b0;
        end

        st_pend_d = st_req || (st_pend_q && !take_st);
    end

    // Pending registers and sticky error flags (a set event beats clr_flags)
    always_ff @(posedge dtc_clk) begin
        if (rst) begin
            rdo_cnt_q    <= '0;
            rd_pend_q    <= 1'b0;
            rd_addr_q    <= '0;
            st_pend_q    <= 1'b0;
            rdo_overflow <= 1'b0;
            rd_drop      <= 1'b0;
            rd_timeout   <= 1'b0;
            tx_lost      <= 1'b0;
        end else begin
            rdo_cnt_q    <= rdo_cnt_d;
            rd_pend_q    <= rd_pend_d;
            rd_addr_q    <= rd_addr_d;
            st_pend_q    <= st_pend_d;
            rdo_overflow <= ovf_evt  || (rdo_overflow && !clr_flags);
            rd_drop      <= drop_evt || (rd_drop      && !clr_flags);
            rd_timeout   <= to_evt   || (rd_timeout   && !clr_flags);
            tx_lost      <= lost_evt || (tx_lost      && !clr_flags);
        end
    end

    // Command FSM with registered command pulses and read-reply handshake
    always_ff @(posedge dtc_clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cur_kind_q  <= K_NONE;
            st_cnt_q    <= '0;
            to_cnt_q    <= '0;
            tx_rdocmd   <= 1'b0;
            tx_read     <= 1'b0;
            tx_streq    <= 1'b0;
            tx_address  <= '0;
            tx_data     <= '0;
            tx_data_vld <= 1'b0;
        end else begin
            tx_rdocmd <= 1'b0;
            tx_read   <= 1'b0;
            tx_streq  <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    to_cnt_q <= '0;
                    if (launch) begin
                        cur_kind_q <= sel_kind;
                        state_q    <= S_ISSUE;
                        tx_rdocmd  <= (sel_kind == K_RDO);
                        tx_read    <= (sel_kind == K_RD);
                        tx_streq   <= (sel_kind == K_ST);
                        if (sel_kind == K_RD) begin
                            tx_address  <= rd_addr_q;
                            tx_data_vld <= 1'b0;
                        end
                    end
                end
                S_ISSUE: begin
                    st_cnt_q <= '0;
                    state_q  <= S_WAIT_START;
                end
                S_WAIT_START: begin
                    if (!tx_idle)
                        state_q <= S_WAIT_DONE;
                    else if (lost_evt)
                        state_q <= S_IDLE;
                    else
                        st_cnt_q <= st_cnt_q + 1'b1;
                end
                S_WAIT_DONE: begin
                    if (tx_idle)
                        state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase

            if (rd_active) begin
                if (to_cnt_q != TO_LAST)
                    to_cnt_q <= to_cnt_q + 1'b1;
                if (!tx_data_vld && rd_data_vld) begin
                    tx_data     <= rd_data;
                    tx_data_vld <= 1'b1;
                end else if (to_evt) begin
                    tx_data     <= RD_DUMMY;
                    tx_data_vld <= 1'b1;
                end
            end

            // The reply is only valid for the transaction that produced it
            if (to_idle)
                tx_data_vld <= 1'b0;
        end
    end

    assign rdo_pending = rdo_cnt_q;
    assign busy        = (state_q != S_IDLE) || any_pend;

endmodule

// File: tb/tb_dtc_tx_sched.sv
// Directed self-checking bench for dtc_tx_sched; the transmitter is emulated
// by driving tx_idle by hand.
module tb_dtc_tx_sched;

    logic        dtc_clk;
    logic        rst;
    logic        trig_rdo;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        st_req;
    logic [31:0] rd_data;
    logic        rd_data_vld;
    logic        clr_flags;
    logic        tx_idle;
    logic        tx_rdocmd;
    logic        tx_read;
    logic        tx_streq;
    logic [31:0] tx_address;
    logic [31:0] tx_data;
    logic        tx_data_vld;
    logic [2:0]  rdo_pending;
    logic        busy;
    logic        rdo_overflow;
    logic        rd_drop;
    logic        rd_timeout;
    logic        tx_lost;

    int checks   = 0;
    int failures = 0;
    int n_rdo    = 0;
    int n_rd     = 0;
    int n_st     = 0;

    dtc_tx_sched #(
        .RDO_DEPTH  (4),
        .RD_TIMEOUT (255),
        .START_LIMIT(15),
        .RD_DUMMY   (32'hDEAD_DEAD)
    ) dut (
        .dtc_clk     (dtc_clk),
        .rst         (rst),
        .trig_rdo    (trig_rdo),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .st_req      (st_req),
        .rd_data     (rd_data),
        .rd_data_vld (rd_data_vld),
        .clr_flags   (clr_flags),
        .tx_idle     (tx_idle),
        .tx_rdocmd   (tx_rdocmd),
        .tx_read     (tx_read),
        .tx_streq    (tx_streq),
        .tx_address  (tx_address),
        .tx_data     (tx_data),
        .tx_data_vld (tx_data_vld),
        .rdo_pending (rdo_pending),
        .busy        (busy),
        .rdo_overflow(rdo_overflow),
        .rd_drop     (rd_drop),
        .rd_timeout  (rd_timeout),
        .tx_lost     (tx_lost)
    );

    initial dtc_clk = 1'b0;
    always #5 dtc_clk = ~dtc_clk;

    // Count command pulses, sampled mid-cycle
    always @(negedge dtc_clk) begin
        if (!rst) begin
            n_rdo <= n_rdo + int'(tx_rdocmd);
            n_rd  <= n_rd  + int'(tx_read);
            n_st  <= n_st  + int'(tx_streq);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit");
    end

    task automatic tick();
        @(posedge dtc_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_cmd(output logic [2:0] cmds, output int cyc);
        cmds = 3'b000;
        cyc  = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if ({tx_rdocmd, tx_read, tx_streq} != 3'b000) begin
                cmds = {tx_rdocmd, tx_read, tx_streq};
                cyc  = i;
                break;
            end
        end
    endtask

    task automatic serve();
        tx_idle = 1'b0;
        repeat (3) tick();
        tx_idle = 1'b1;
    endtask

    initial begin
        logic [2:0] c;
        int         cy;
        int         b_rdo, b_rd, b_st;

        rst = 1'b1; trig_rdo = 1'b0; rd_req = 1'b0; rd_addr = '0; st_req = 1'b0;
        rd_data = '0; rd_data_vld = 1'b0; clr_flags = 1'b0; tx_idle = 1'b1;
        repeat (3) tick();

        // Reset state
        chk("rst_cmds", 32'({tx_rdocmd, tx_read, tx_streq}), 32'd0);
        chk("rst_addr", tx_address, 32'd0);
        chk("rst_data", {tx_data[31:1], tx_data_vld}, 32'd0);
        chk("rst_pend_busy", {28'd0, rdo_pending, busy}, 32'd0);
        chk("rst_flags", 32'({rdo_overflow, rd_drop, rd_timeout, tx_lost}), 32'd0);
        rst = 1'b0;
        tick();

        // Single read with data returned 10 cycles after the request
        b_rd = n_rd;
        rd_addr = 32'h0000_0040; rd_req = 1'b1;
        tick();
        rd_req = 1'b0; rd_addr = 32'h0000_0000;
        chk("rd1_no_cmd_yet", 32'(tx_read), 32'd0);
        chk("rd1_busy", 32'(busy), 32'd1);
        tick();
        chk("rd1_tx_read", 32'(tx_read), 32'd1);
        chk("rd1_addr", tx_address, 32'h0000_0040);
        tx_idle = 1'b0;
        tick();
        chk("rd1_read_width", 32'(tx_read), 32'd0);
        repeat (7) tick();
        chk("rd1_vld_before", 32'(tx_data_vld), 32'd0);
        rd_data = 32'h1234_5678; rd_data_vld = 1'b1;
        tick();
        rd_data = 32'hAAAA_5555;
        chk("rd1_vld", 32'(tx_data_vld), 32'd1);
        chk("rd1_data", tx_data, 32'h1234_5678);
        tick();
        rd_data_vld = 1'b0;
        tick();
        chk("rd1_first_only", tx_data, 32'h1234_5678);
        chk("rd1_vld_held", 32'(tx_data_vld), 32'd1);
        tx_idle = 1'b1;
        tick();
        chk("rd1_vld_clr", 32'(tx_data_vld), 32'd0);
        chk("rd1_data_keep", tx_data, 32'h1234_5678);
        chk("rd1_busy_end", 32'(busy), 32'd0);
        chk("rd1_one_pulse", 32'(n_rd - b_rd), 32'd1);

        // Read data outside a read transaction is ignored
        rd_data = 32'hBBBB_BBBB; rd_data_vld = 1'b1;
        tick();
        rd_data_vld = 1'b0;
        tick();
        chk("idle_vld_ignored", 32'(tx_data_vld), 32'd0);
        chk("idle_data_ignored", tx_data, 32'h1234_5678);

        // Read timeout, plus a second read request dropped while active
        b_rd = n_rd;
        rd_addr = 32'h0000_0080; rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        chk("rd2_tx_read", 32'(tx_read), 32'd1);
        chk("rd2_addr", tx_address, 32'h0000_0080);
        tx_idle = 1'b0;
        tick();
        tick();
        rd_addr = 32'h0000_0099; rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("rd2_drop", 32'(rd_drop), 32'd1);
        repeat (252) tick();
        chk("rd2_vld_pre_to", 32'({rd_timeout, tx_data_vld}), 32'd0);
        tick();
        chk("rd2_vld_to", 32'({rd_timeout, tx_data_vld}), 32'd3);
        chk("rd2_dummy", tx_data, 32'hDEAD_DEAD);
        tx_idle = 1'b1;
        tick();
        chk("rd2_sticky", 32'({rd_drop, rd_timeout, tx_data_vld}), 32'd6);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("rd2_flags_clr", 32'({rdo_overflow, rd_drop, rd_timeout, tx_lost}), 32'd0);
        repeat (3) tick();
        chk("rd2_one_read", 32'(n_rd - b_rd), 32'd1);

        // Priority: simultaneous readout, read and status requests
        b_rdo = n_rdo; b_rd = n_rd; b_st = n_st;
        trig_rdo = 1'b1; rd_req = 1'b1; st_req = 1'b1; rd_addr = 32'h0000_001C;
        tick();
        trig_rdo = 1'b0; rd_req = 1'b0; st_req = 1'b0;
        chk("pri_pending", 32'(rdo_pending), 32'd1);
        wait_cmd(c, cy);
        chk("pri_first", {c, 29'(cy)}, {3'b100, 29'd1});
        serve();
        wait_cmd(c, cy);
        chk("pri_second", {c, 29'(cy)}, {3'b010, 29'd2});
        chk("pri_addr", tx_address, 32'h0000_001C);
        serve();
        wait_cmd(c, cy);
        chk("pri_third", {c, 29'(cy)}, {3'b001, 29'd2});
        serve();
        wait_cmd(c, cy);
        chk("pri_no_more", 32'(c), 32'd0);
        chk("pri_counts", 32'((n_rdo - b_rdo) + (n_rd - b_rd) + (n_st - b_st)), 32'd3);
        chk("pri_busy", 32'(busy), 32'd0);

        // Overflow: 6 readout triggers while the transmitter is busy;
        // clr_flags coincides with the last overflowing trigger
        b_rdo = n_rdo;
        tx_idle = 1'b0;
        trig_rdo = 1'b1;
        repeat (5) tick();
        clr_flags = 1'b1;
        tick();
        trig_rdo = 1'b0; clr_flags = 1'b0;
        chk("ovf_pending", 32'(rdo_pending), 32'd4);
        chk("ovf_flag", 32'(rdo_overflow), 32'd1);
        tx_idle = 1'b1;
        for (int n = 0; n < 4; n++) begin
            wait_cmd(c, cy);
            chk("ovf_cmd", 32'(c), 32'b100);
            serve();
        end
        wait_cmd(c, cy);
        chk("ovf_no_fifth", 32'(c), 32'd0);
        chk("ovf_count", 32'(n_rdo - b_rdo), 32'd4);
        chk("ovf_pending_end", 32'(rdo_pending), 32'd0);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("ovf_clr", 32'(rdo_overflow), 32'd0);

        // Lost transmitter: tx_idle stays high after a status command
        b_st = n_st;
        st_req = 1'b1;
        tick();
        st_req = 1'b0;
        wait_cmd(c, cy);
        chk("lost_cmd", {c, 29'(cy)}, {3'b001, 29'd1});
        repeat (15) tick();
        chk("lost_pre", 32'({tx_lost, busy}), 32'd1);
        tick();
        chk("lost_set", 32'({tx_lost, busy}), 32'd2);
        repeat (5) tick();
        chk("lost_single", 32'(n_st - b_st), 32'd1);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;

        // Reset in the middle of a read
        rd_addr = 32'h0000_0044; rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        wait_cmd(c, cy);
        chk("mid_cmd", 32'(c), 32'b010);
        tx_idle = 1'b0;
        tick();
        tick();
        rd_data = 32'h5555_AAAA; rd_data_vld = 1'b1; trig_rdo = 1'b1; rd_req = 1'b1;
        tick();
        rd_data_vld = 1'b0; trig_rdo = 1'b0; rd_req = 1'b0;
        chk("mid_state", 32'({tx_data_vld, rd_drop, rdo_pending}), 32'h0000_0019);
        rst = 1'b1;
        tick();
        rst = 1'b0; tx_idle = 1'b1;
        chk("mid_rst_out", 32'({tx_rdocmd, tx_read, tx_streq, tx_data_vld, rdo_pending, busy}), 32'd0);
        chk("mid_rst_bus", tx_address | tx_data, 32'd0);
        chk("mid_rst_flags", 32'({rdo_overflow, rd_drop, rd_timeout, tx_lost}), 32'd0);
        st_req = 1'b1;
        tick();
        st_req = 1'b0;
        wait_cmd(c, cy);
        chk("post_rst_st", {c, 29'(cy)}, {3'b001, 29'd1});
        serve();
        tick();
        chk("post_rst_idle", 32'({busy, tx_lost}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
